// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the memory responder: FSM state encoding,
// parameter defaults and the request-protocol error check.
package mem_responder_pkg;

    localparam int DEF_ADDR_WIDTH  = 5;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_WAIT_STATES = 1;
    localparam int CNT_WIDTH       = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_WAIT   = 3'd1,
        ST_RD_DATA   = 3'd2,
        ST_WR_WAIT   = 3'd3,
        ST_WR_COMMIT = 3'd4
    } state_e;

    // A request is malformed when read and write collide or a write lacks data_e.
    function automatic logic req_error(input logic rd, input logic wr, input logic data_e);
        return (rd & wr) | (wr & ~data_e);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side request/response bundle of the memory responder, including the
// program preload port.
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) ();

    logic [ADDR_WIDTH-1:0] addr;
    logic                  rd;
    logic                  wr;
    logic                  data_e;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  err_clr;
    logic                  ld_en;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  ready;
    logic                  wack;
    logic                  err;

    modport master (
        output addr, rd, wr, data_e, wdata, err_clr, ld_en, ld_addr, ld_data,
        input  rdata, rvalid, ready, wack, err
    );

    modport slave (
        input  addr, rd, wr, data_e, wdata, err_clr, ld_en, ld_addr, ld_data,
        output rdata, rvalid, ready, wack, err
    );

endinterface

// File: rtl/mem_responder_rsp_mem_array.sv
// Word storage for the responder: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module rsp_mem_array #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder for a simple CPU: handshaked reads, strobed
// writes with commit acknowledge, sticky protocol error and a preload port.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic            clk,
    input  logic            n_rst,
    mem_responder_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    // Counter preload so the wait state lasts exactly WAIT_STATES cycles.
    localparam logic [CNT_WIDTH-1:0] WAIT_INIT =
        (WAIT_STATES == 0) ? CNT_ZERO : CNT_WIDTH'(WAIT_STATES - 1);

    state_e                state_r;
    state_e                state_nxt_s;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [CNT_WIDTH-1:0]  cnt_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  rvalid_r;
    logic                  wack_r;
    logic                  err_r;

    logic                  ready_s;
    logic                  accept_rd_s;
    logic                  accept_wr_s;
    logic                  err_set_s;
    logic                  load_rdata_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_waddr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic [ADDR_WIDTH-1:0] mem_raddr_s;
    logic [DATA_WIDTH-1:0] mem_rdata_s;

    assign ready_s      = (state_r == ST_IDLE) && !bus.ld_en;
    assign accept_rd_s  = ready_s && bus.rd && !bus.wr;
    assign accept_wr_s  = ready_s && bus.wr && bus.data_e && !bus.rd;
    assign err_set_s    = ready_s && req_error(bus.rd, bus.wr, bus.data_e);
    // With zero wait states the read is served from the live address bus.
    assign mem_raddr_s  = (state_r == ST_IDLE) ? bus.addr : addr_r;
    assign load_rdata_s = (state_nxt_s == ST_RD_DATA) && (state_r != ST_RD_DATA);

    // FSM state and wait counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_rd_s) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt_s = ST_RD_DATA;
                    end else begin
                        state_nxt_s = ST_RD_WAIT;
                        cnt_nxt_s   = WAIT_INIT;
                    end
                end else if (accept_wr_s) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt_s = ST_WR_COMMIT;
                    end else begin
                        state_nxt_s = ST_WR_WAIT;
                        cnt_nxt_s   = WAIT_INIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            // A read abandoned during the wait still completes with one rvalid cycle.
            ST_RD_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_RD_DATA;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_RD_DATA: begin
                if (bus.rd) begin
                    state_nxt_s = ST_RD_DATA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_WR_COMMIT;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_WR_COMMIT: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Write-port arbitration: CPU commit or preload, the latter only in IDLE.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = bus.ld_addr;
        mem_wdata_s = bus.ld_data;
        if (state_r == ST_WR_COMMIT) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = addr_r;
            mem_wdata_s = wdata_r;
        end else if ((state_r == ST_IDLE) && bus.ld_en) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = bus.ld_addr;
            mem_wdata_s = bus.ld_data;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Request capture; later bus changes are ignored until the access ends.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r <= {DATA_WIDTH{1'b0}};
        end else if (accept_rd_s || accept_wr_s) begin
            addr_r  <= bus.addr;
            wdata_r <= bus.wdata;
        end
    end

    // Registered response outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rdata_r  <= {DATA_WIDTH{1'b0}};
            rvalid_r <= 1'b0;
            wack_r   <= 1'b0;
        end else begin
            if (load_rdata_s) begin
                rdata_r <= mem_rdata_s;
            end
            rvalid_r <= (state_nxt_s == ST_RD_DATA);
            wack_r   <= (state_nxt_s == ST_WR_COMMIT);
        end
    end

    // Sticky error: a new error wins over a simultaneous clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else if (bus.err_clr) begin
            err_r <= 1'b0;
        end
    end

    rsp_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (mem_waddr_s),
        .wdata (mem_wdata_s),
        .raddr (mem_raddr_s),
        .rdata (mem_rdata_s)
    );

    assign bus.rdata  = rdata_r;
    assign bus.rvalid = rvalid_r;
    assign bus.ready  = ready_s;
    assign bus.wack   = wack_r;
    assign bus.err    = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a one-wait-state instance (dut_a) and a
// zero-wait-state instance (dut_b), inputs driven and outputs checked on negedge.
module tb_mem_responder;

    logic clk;
    logic n_rst;
    int   vectors;
    int   miscompares;

    mem_responder_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus_a ();
    mem_responder_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus_b ();

    mem_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .WAIT_STATES(1)) dut_a (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_a)
    );

    mem_responder #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .WAIT_STATES(0)) dut_b (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_a(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_a.ld_en = 1'b1; bus_a.ld_addr = a; bus_a.ld_data = d;
        @(negedge clk);
        bus_a.ld_en = 1'b0;
    endtask

    task automatic load_b(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_b.ld_en = 1'b1; bus_b.ld_addr = a; bus_b.ld_data = d;
        @(negedge clk);
        bus_b.ld_en = 1'b0;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus_a.rdata !== 8'h00) begin miscompares++; $display("FAIL reset_rdata: got %h expected 00", bus_a.rdata); end
        vectors++;
        if ({bus_a.rvalid, bus_a.wack, bus_a.err} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags: got rvalid/wack/err=%b expected 000", {bus_a.rvalid, bus_a.wack, bus_a.err});
        end
        n_rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_a.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", bus_a.ready); end
    endtask

    task automatic test_preload_read;
        load_a(5'd3, 8'hA5);
        bus_a.rd = 1'b1; bus_a.addr = 5'd3;
        @(negedge clk);
        vectors++;
        if (bus_a.rvalid !== 1'b0) begin miscompares++; $display("FAIL read_wait_rvalid: got %b expected 0", bus_a.rvalid); end
        bus_a.addr = 5'd9;
        @(negedge clk);
        vectors++;
        if (bus_a.rvalid !== 1'b1 || bus_a.rdata !== 8'hA5) begin
            miscompares++; $display("FAIL read_data: got rvalid=%b rdata=%h expected 1 a5", bus_a.rvalid, bus_a.rdata);
        end
        @(negedge clk);
        vectors++;
        if (bus_a.rvalid !== 1'b1) begin miscompares++; $display("FAIL read_hold: got %b expected 1", bus_a.rvalid); end
        bus_a.rd = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus_a.rvalid !== 1'b0 || bus_a.ready !== 1'b1) begin
            miscompares++; $display("FAIL read_release: got rvalid=%b ready=%b expected 0 1", bus_a.rvalid, bus_a.ready);
        end
    endtask

    task automatic test_write;
        bus_a.wr = 1'b1; bus_a.data_e = 1'b1; bus_a.addr = 5'd7; bus_a.wdata = 8'h3C;
        @(negedge clk);
        bus_a.wr = 1'b0; bus_a.data_e = 1'b0; bus_a.wdata = 8'hFF;
        vectors++;
        if (bus_a.wack !== 1'b0) begin miscompares++; $display("FAIL write_wait_wack: got %b expected 0", bus_a.wack); end
        @(negedge clk);
        vectors++;
        if (bus_a.wack !== 1'b1) begin miscompares++; $display("FAIL write_wack: got %b expected 1", bus_a.wack); end
        @(negedge clk);
        vectors++;
        if (bus_a.wack !== 1'b0 || bus_a.ready !== 1'b1) begin
            miscompares++; $display("FAIL write_done: got wack=%b ready=%b expected 0 1", bus_a.wack, bus_a.ready);
        end
        bus_a.rd = 1'b1; bus_a.addr = 5'd7;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus_a.rvalid !== 1'b1 || bus_a.rdata !== 8'h3C) begin
            miscompares++; $display("FAIL write_readback: got rvalid=%b rdata=%h expected 1 3c", bus_a.rvalid, bus_a.rdata);
        end
        bus_a.rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_error;
        bus_a.wr = 1'b1; bus_a.data_e = 1'b0; bus_a.addr = 5'd7; bus_a.wdata = 8'h99;
        @(negedge clk);
        bus_a.wr = 1'b0;
        vectors++;
        if (bus_a.err !== 1'b1 || bus_a.ready !== 1'b1) begin
            miscompares++; $display("FAIL err_set: got err=%b ready=%b expected 1 1", bus_a.err, bus_a.ready);
        end
        @(negedge clk);
        vectors++;
        if (bus_a.wack !== 1'b0) begin miscompares++; $display("FAIL err_no_access: got wack=%b expected 0", bus_a.wack); end
        bus_a.err_clr = 1'b1;
        @(negedge clk);
        bus_a.err_clr = 1'b0;
        vectors++;
        if (bus_a.err !== 1'b0) begin miscompares++; $display("FAIL err_clear: got %b expected 0", bus_a.err); end
        bus_a.rd = 1'b1; bus_a.wr = 1'b1; bus_a.data_e = 1'b1; bus_a.err_clr = 1'b1;
        @(negedge clk);
        bus_a.rd = 1'b0; bus_a.wr = 1'b0; bus_a.data_e = 1'b0; bus_a.err_clr = 1'b0;
        vectors++;
        if (bus_a.err !== 1'b1 || bus_a.ready !== 1'b1) begin
            miscompares++; $display("FAIL err_set_beats_clr: got err=%b ready=%b expected 1 1", bus_a.err, bus_a.ready);
        end
        bus_a.err_clr = 1'b1;
        @(negedge clk);
        bus_a.err_clr = 1'b0;
        bus_a.rd = 1'b1; bus_a.addr = 5'd7;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus_a.rdata !== 8'h3C || bus_a.err !== 1'b0) begin
            miscompares++; $display("FAIL err_mem_unchanged: got rdata=%h err=%b expected 3c 0", bus_a.rdata, bus_a.err);
        end
        bus_a.rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_collision;
        bus_a.ld_en = 1'b1; bus_a.ld_addr = 5'd10; bus_a.ld_data = 8'h5A;
        bus_a.rd = 1'b1; bus_a.addr = 5'd10;
        #1;
        vectors++;
        if (bus_a.ready !== 1'b0) begin miscompares++; $display("FAIL load_ready_low: got %b expected 0", bus_a.ready); end
        @(negedge clk);
        bus_a.ld_en = 1'b0;
        #1;
        vectors++;
        if (bus_a.ready !== 1'b1) begin miscompares++; $display("FAIL load_rd_ignored: got ready=%b expected 1", bus_a.ready); end
        @(negedge clk);
        vectors++;
        if (bus_a.ready !== 1'b0 || bus_a.rvalid !== 1'b0) begin
            miscompares++; $display("FAIL load_rd_accept: got ready=%b rvalid=%b expected 0 0", bus_a.ready, bus_a.rvalid);
        end
        @(negedge clk);
        vectors++;
        if (bus_a.rvalid !== 1'b1 || bus_a.rdata !== 8'h5A) begin
            miscompares++; $display("FAIL load_rd_data: got rvalid=%b rdata=%h expected 1 5a", bus_a.rvalid, bus_a.rdata);
        end
        bus_a.rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rd_drop;
        bus_a.rd = 1'b1; bus_a.addr = 5'd3;
        @(negedge clk);
        bus_a.rd = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus_a.rvalid !== 1'b1 || bus_a.rdata !== 8'hA5) begin
            miscompares++; $display("FAIL drop_pulse: got rvalid=%b rdata=%h expected 1 a5", bus_a.rvalid, bus_a.rdata);
        end
        @(negedge clk);
        vectors++;
        if (bus_a.rvalid !== 1'b0 || bus_a.ready !== 1'b1) begin
            miscompares++; $display("FAIL drop_idle: got rvalid=%b ready=%b expected 0 1", bus_a.rvalid, bus_a.ready);
        end
    endtask

    task automatic test_reset_mid_write;
        load_a(5'd12, 8'h11);
        bus_a.rd = 1'b1; bus_a.wr = 1'b1; bus_a.data_e = 1'b1;
        @(negedge clk);
        bus_a.rd = 1'b0; bus_a.addr = 5'd12; bus_a.wdata = 8'h77;
        @(negedge clk);
        bus_a.wr = 1'b0; bus_a.data_e = 1'b0;
        n_rst = 1'b0;
        #1;
        vectors++;
        if ({bus_a.rvalid, bus_a.wack, bus_a.err, bus_a.ready} !== 4'b0001 || bus_a.rdata !== 8'h00) begin
            miscompares++; $display("FAIL rst_mid_outputs: got rvalid/wack/err/ready=%b rdata=%h expected 0001 00",
                {bus_a.rvalid, bus_a.wack, bus_a.err, bus_a.ready}, bus_a.rdata);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_a.wack !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_wack: got %b expected 0", bus_a.wack); end
        bus_a.rd = 1'b1; bus_a.addr = 5'd12;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus_a.rvalid !== 1'b1 || bus_a.rdata !== 8'h11) begin
            miscompares++; $display("FAIL rst_mid_mem_kept: got rvalid=%b rdata=%h expected 1 11", bus_a.rvalid, bus_a.rdata);
        end
        bus_a.rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_wait;
        load_b(5'd31, 8'hC3);
        bus_b.rd = 1'b1; bus_b.addr = 5'd31;
        @(negedge clk);
        vectors++;
        if (bus_b.rvalid !== 1'b1 || bus_b.rdata !== 8'hC3) begin
            miscompares++; $display("FAIL zw_read: got rvalid=%b rdata=%h expected 1 c3", bus_b.rvalid, bus_b.rdata);
        end
        bus_b.rd = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus_b.rvalid !== 1'b0) begin miscompares++; $display("FAIL zw_read_end: got %b expected 0", bus_b.rvalid); end
        bus_b.wr = 1'b1; bus_b.data_e = 1'b1; bus_b.addr = 5'd0; bus_b.wdata = 8'h42;
        @(negedge clk);
        bus_b.wr = 1'b0; bus_b.data_e = 1'b0;
        vectors++;
        if (bus_b.wack !== 1'b1) begin miscompares++; $display("FAIL zw_wack: got %b expected 1", bus_b.wack); end
        @(negedge clk);
        bus_b.rd = 1'b1; bus_b.addr = 5'd0;
        @(negedge clk);
        vectors++;
        if (bus_b.rvalid !== 1'b1 || bus_b.rdata !== 8'h42) begin
            miscompares++; $display("FAIL zw_readback: got rvalid=%b rdata=%h expected 1 42", bus_b.rvalid, bus_b.rdata);
        end
        bus_b.rd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        n_rst       = 1'b0;
        bus_a.addr = 5'd0; bus_a.rd = 1'b0; bus_a.wr = 1'b0; bus_a.data_e = 1'b0;
        bus_a.wdata = 8'h00; bus_a.err_clr = 1'b0; bus_a.ld_en = 1'b0;
        bus_a.ld_addr = 5'd0; bus_a.ld_data = 8'h00;
        bus_b.addr = 5'd0; bus_b.rd = 1'b0; bus_b.wr = 1'b0; bus_b.data_e = 1'b0;
        bus_b.wdata = 8'h00; bus_b.err_clr = 1'b0; bus_b.ld_en = 1'b0;
        bus_b.ld_addr = 5'd0; bus_b.ld_data = 8'h00;

        test_reset;
        test_preload_read;
        test_write;
        test_error;
        test_load_collision;
        test_rd_drop;
        test_reset_mid_write;
        test_zero_wait;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, SHALL set the word address width (depth 2**ADDR_WIDTH).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the word width.
REQ-003 Parameter WAIT_STATES, default 1, range 0..7, SHALL set the wait cycles inserted before each read/write completes.
REQ-004 Reset n_rst, asynchronous, active-low; clock clk.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 n_rst  input  1  asynchronous active-low reset.
REQ-007 addr  input  ADDR_WIDTH  word address from CPU controller.
REQ-008 rd  input  1  read request, held high by CPU until data taken.
REQ-009 wr  input  1  write strobe, single cycle acceptable.
REQ-010 data_e  input  1  CPU drives wdata; required with wr.
REQ-011 wdata  input  DATA_WIDTH  write data from accumulator.
REQ-012 err_clr  input  1  clears sticky err.
REQ-013 ld_en, ld_addr, ld_data  input  1/ADDR_WIDTH/DATA_WIDTH  program preload port.
REQ-014 rdata  output  DATA_WIDTH  registered read data.
REQ-015 rvalid  output  1  rdata valid for the current read.
REQ-016 ready  output  1  responder accepts a new request this cycle.
REQ-017 wack  output  1  one-cycle pulse on write commit.
REQ-018 err  output  1  sticky protocol error.

Function
REQ-019 States SHALL be IDLE, RD_WAIT, RD_DATA, WR_WAIT, WR_COMMIT.
REQ-020 ready SHALL equal (state==IDLE) && !ld_en; requests SHALL be sampled only when ready=1.
REQ-021 IDLE, ld_en=1: mem[ld_addr]<=ld_data that edge; any concurrent rd/wr ignored (CPU retries by holding).
REQ-022 IDLE, ready, rd=1, wr=0: latch addr; go RD_WAIT, or RD_DATA directly if WAIT_STATES=0.
REQ-023 IDLE, ready, wr=1, data_e=1, rd=0: latch addr and wdata; go WR_WAIT, or WR_COMMIT if WAIT_STATES=0.
REQ-024 RD_WAIT/WR_WAIT SHALL last exactly WAIT_STATES cycles via down-counter; addr/wdata changes ignored.
REQ-025 RD_DATA: rdata<=mem[latched addr] on entry edge; rvalid=1 while in RD_DATA; stay while rd=1; rd=0 -> IDLE, rvalid=0 next cycle.
REQ-026 rd dropped during RD_WAIT: read completes internally, rvalid pulses one cycle, return IDLE.
REQ-027 WR_COMMIT: memory written, wack=1 one cycle, next state IDLE irrespective of wr.
REQ-028 Read latency: rvalid high WAIT_STATES+1 cycles after the accepting edge.
REQ-029 Error (ready=1): rd&wr together, or wr without data_e -> err<=1, no access, stay IDLE.
REQ-030 err SHALL stay 1 until err_clr=1; simultaneous new error and err_clr -> err remains 1.
REQ-031 Address space full-decoded; no wrap logic beyond ADDR_WIDTH truncation.

Reset
REQ-032 n_rst low: state=IDLE, counter=0, rdata=0, rvalid=0, wack=0, err=0; ready=1 after release.
REQ-033 Reset mid-operation SHALL discard a pending write; memory array contents SHALL NOT be reset.

Structure
REQ-034 Package mem_responder_pkg SHALL hold the state enum and WAIT_STATES/width defaults.
REQ-035 Storage SHALL be sub-module rsp_mem_array (one sync write port, one read port), shared by preload and CPU write via IDLE-only arbitration.

Verification
REQ-036 Preload mem[3]=8'hA5, WAIT_STATES=1, rd addr=3 held -> rvalid high 2 cycles after accept, rdata=8'hA5.
REQ-037 wr=1, data_e=1, addr=7, wdata=8'h3C one cycle -> wack after 2 cycles; later read of 7 returns 8'h3C.
REQ-038 wr=1, data_e=0 -> err=1, mem unchanged; err_clr -> err=0 next cycle.
REQ-039 ld_en=1 with rd=1 same cycle -> ready=0, load done; read accepted next cycle.
REQ-040 n_rst low during WR_WAIT -> no wack, mem[addr] keeps old value, outputs at reset values.
REQ-041 WAIT_STATES=0 read of addr 31 -> rvalid next cycle, correct data.
